// File: rtl/rib_mem_responder.sv
// rib_mem_responder: responder end of the RIB data-memory bus.
// Services core reads/writes from a word RAM after WAIT_CYCLES wait states.
module rib_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int WAIT_CYCLES = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  wr_req_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  hold_o,
    output logic                  err_o
);

    localparam int TAG_LO = DEPTH_LOG2 + 2;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam bit ONE_WAIT = (WAIT_CYCLES == 1);

    // The IDLE accept cycle already counts as the first wait state,
    // so a fresh transaction loads one less than a chained read does.
    localparam logic [3:0] CNT_FIRST =
        (WAIT_CYCLES > 1) ? 4'(WAIT_CYCLES - 2) : 4'd0;
    localparam logic [3:0] CNT_CHAIN =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EXEC
    } state_t;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    state_t                state;
    logic [3:0]            cnt;
    logic                  lat_wr;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_data;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_pend;

    logic                  wr_req;
    logic                  any_req;
    logic                  both_req;
    logic                  ex_go;
    logic                  ex_wr;
    logic [ADDR_WIDTH-1:0] ex_addr;
    logic [DATA_WIDTH-1:0] ex_data;
    logic                  ex_hit;
    logic [DEPTH_LOG2-1:0] ex_idx;

    assign wr_req   = wr_req_i & wr_en_i;
    assign any_req  = wr_req | rd_req_i;
    assign both_req = wr_req & rd_req_i;

    // With no wait states the IDLE cycle is itself the execute cycle.
    assign ex_go = (state == S_EXEC) ||
                   ((state == S_IDLE) && any_req && NO_WAIT);

    always_comb begin
        ex_wr   = lat_wr;
        ex_addr = lat_addr;
        ex_data = lat_data;
        if (state != S_EXEC) begin
            ex_wr   = wr_req;
            ex_addr = wr_req ? wr_addr_i : rd_addr_i;
            ex_data = wr_data_i;
        end
    end

    assign ex_hit =
        (ex_addr[ADDR_WIDTH-1:TAG_LO] == BASE_ADDR[ADDR_WIDTH-1:TAG_LO]) &&
        (ex_addr[1:0] == 2'b00);
    assign ex_idx = ex_addr[TAG_LO-1:2];

    always_comb begin
        hold_o = 1'b0;
        unique case (state)
            S_IDLE: hold_o = any_req && (!NO_WAIT || both_req);
            S_WAIT: hold_o = 1'b1;
            S_EXEC: hold_o = rd_pend;
            default: hold_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && ex_go && ex_wr && ex_hit) begin
            mem[ex_idx] <= ex_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            rd_addr_q  <= '0;
            rd_pend    <= 1'b0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            err_o      <= 1'b0;
            if (ex_go) begin
                err_o <= !ex_hit;
                if (!ex_wr) begin
                    rd_valid_o <= 1'b1;
                    rd_data_o  <= ex_hit ? mem[ex_idx] : '0;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        lat_wr    <= wr_req;
                        lat_addr  <= wr_req ? wr_addr_i : rd_addr_i;
                        lat_data  <= wr_data_i;
                        rd_addr_q <= rd_addr_i;
                        rd_pend   <= both_req;
                        if (NO_WAIT) begin
                            // write done this cycle; run the read next
                            if (both_req) begin
                                lat_wr   <= 1'b0;
                                lat_addr <= rd_addr_i;
                                rd_pend  <= 1'b0;
                                state    <= S_EXEC;
                            end
                        end else if (ONE_WAIT) begin
                            state <= S_EXEC;
                        end else begin
                            cnt   <= CNT_FIRST;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_EXEC;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_EXEC: begin
                    if (rd_pend) begin
                        rd_pend  <= 1'b0;
                        lat_wr   <= 1'b0;
                        lat_addr <= rd_addr_q;
                        if (NO_WAIT) begin
                            state <= S_EXEC;
                        end else begin
                            cnt   <= CNT_CHAIN;
                            state <= S_WAIT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rib_mem_responder.sv
// tb_rib_mem_responder: table-driven cycle checks of two responders,
// one with WAIT_CYCLES=2 and one with WAIT_CYCLES=0, sharing stimulus.
module tb_rib_mem_responder;

    localparam logic [31:0] BA = 32'h1000_0000;
    localparam logic [31:0] MISS = 32'h2000_0000;

    typedef struct {
        logic        rs;
        logic        rd;
        logic [31:0] ra;
        logic        wr;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        hold;
        logic        vld;
        logic [31:0] dat;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        wr_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        hold_a, hold_b;
    logic        err_a, err_b;

    int passed = 0;
    int total = 0;
    vec_t tab[$];

    always #5 clk = ~clk;

    rib_mem_responder #(
        .DEPTH_LOG2(4), .WAIT_CYCLES(2), .BASE_ADDR(BA)
    ) dut_a (
        .clk(clk), .rst(rst),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a),
        .wr_req_i(wr_req), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .hold_o(hold_a), .err_o(err_a)
    );

    rib_mem_responder #(
        .DEPTH_LOG2(4), .WAIT_CYCLES(0), .BASE_ADDR(BA)
    ) dut_b (
        .clk(clk), .rst(rst),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b),
        .wr_req_i(wr_req), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .hold_o(hold_b), .err_o(err_b)
    );

    function automatic vec_t v(
        logic rs, logic rd, logic [31:0] ra,
        logic wr, logic we, logic [31:0] wa, logic [31:0] wd,
        logic h, logic vl, logic [31:0] d, logic e);
        vec_t r;
        r.rs = rs; r.rd = rd; r.ra = ra;
        r.wr = wr; r.we = we; r.wa = wa; r.wd = wd;
        r.hold = h; r.vld = vl; r.dat = d; r.err = e;
        return r;
    endfunction

    function automatic vec_t idl(logic h, logic vl, logic [31:0] d, logic e);
        return v(0, 0, '0, 0, 0, '0, '0, h, vl, d, e);
    endfunction

    function automatic vec_t rdq(logic [31:0] a,
        logic h, logic vl, logic [31:0] d, logic e);
        return v(0, 1, a, 0, 0, '0, '0, h, vl, d, e);
    endfunction

    function automatic vec_t wrq(logic [31:0] a, logic [31:0] wd,
        logic h, logic vl, logic [31:0] d, logic e);
        return v(0, 0, '0, 1, 1, a, wd, h, vl, d, e);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic run_table(string tag, bit use_b);
        for (int i = 0; i < tab.size(); i++) begin
            @(posedge clk);
            #1;
            rst = tab[i].rs;
            rd_req = tab[i].rd;
            rd_addr = tab[i].ra;
            wr_req = tab[i].wr;
            wr_en = tab[i].we;
            wr_addr = tab[i].wa;
            wr_data = tab[i].wd;
            @(negedge clk);
            if (use_b) begin
                chk($sformatf("%s[%0d].hold", tag, i), 32'(hold_b), 32'(tab[i].hold));
                chk($sformatf("%s[%0d].vld", tag, i), 32'(rd_valid_b), 32'(tab[i].vld));
                chk($sformatf("%s[%0d].data", tag, i), rd_data_b, tab[i].dat);
                chk($sformatf("%s[%0d].err", tag, i), 32'(err_b), 32'(tab[i].err));
            end else begin
                chk($sformatf("%s[%0d].hold", tag, i), 32'(hold_a), 32'(tab[i].hold));
                chk($sformatf("%s[%0d].vld", tag, i), 32'(rd_valid_a), 32'(tab[i].vld));
                chk($sformatf("%s[%0d].data", tag, i), rd_data_a, tab[i].dat);
                chk($sformatf("%s[%0d].err", tag, i), 32'(err_a), 32'(tab[i].err));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] got;

        // WAIT_CYCLES=2 responder
        tab.delete();
        tab.push_back(idl(0, 0, 0, 0));
        repeat (2) tab.push_back(wrq(BA + 8, 32'hDEAD_BEEF, 1, 0, 0, 0));
        tab.push_back(wrq(BA + 8, 32'hDEAD_BEEF, 0, 0, 0, 0));
        repeat (2) tab.push_back(rdq(BA + 8, 1, 0, 0, 0));
        tab.push_back(rdq(BA + 8, 0, 0, 0, 0));
        tab.push_back(idl(0, 1, 32'hDEAD_BEEF, 0));
        repeat (5)
            tab.push_back(v(0, 1, BA + 4, 1, 1, BA + 4, 32'h1234,
                            1, 0, 32'hDEAD_BEEF, 0));
        tab.push_back(v(0, 1, BA + 4, 1, 1, BA + 4, 32'h1234,
                        0, 0, 32'hDEAD_BEEF, 0));
        tab.push_back(idl(0, 1, 32'h1234, 0));
        tab.push_back(idl(0, 0, 32'h1234, 0));
        repeat (2) tab.push_back(wrq(BA, 32'h1111_2222, 1, 0, 32'h1234, 0));
        tab.push_back(wrq(BA, 32'h1111_2222, 0, 0, 32'h1234, 0));
        repeat (2) tab.push_back(rdq(MISS, 1, 0, 32'h1234, 0));
        tab.push_back(rdq(MISS, 0, 0, 32'h1234, 0));
        tab.push_back(idl(0, 1, 0, 1));
        repeat (2) tab.push_back(wrq(BA + 2, 32'hAAAA_5555, 1, 0, 0, 0));
        tab.push_back(wrq(BA + 2, 32'hAAAA_5555, 0, 0, 0, 0));
        tab.push_back(idl(0, 0, 0, 1));
        repeat (2) tab.push_back(wrq(MISS, 32'h5555_5555, 1, 0, 0, 0));
        tab.push_back(wrq(MISS, 32'h5555_5555, 0, 0, 0, 0));
        tab.push_back(idl(0, 0, 0, 1));
        repeat (3)
            tab.push_back(v(0, 0, '0, 1, 0, BA, 32'hFFFF_FFFF, 0, 0, 0, 0));
        repeat (2) tab.push_back(rdq(BA, 1, 0, 0, 0));
        tab.push_back(rdq(BA, 0, 0, 0, 0));
        tab.push_back(idl(0, 1, 32'h1111_2222, 0));
        repeat (2)
            tab.push_back(wrq(BA + 12, 32'hC0C0_C0C0, 1, 0, 32'h1111_2222, 0));
        tab.push_back(wrq(BA + 12, 32'hC0C0_C0C0, 0, 0, 32'h1111_2222, 0));
        tab.push_back(wrq(BA + 12, 32'hFFFF_FFFF, 1, 0, 32'h1111_2222, 0));
        tab.push_back(v(1, 0, '0, 1, 1, BA + 12, 32'hFFFF_FFFF,
                        1, 0, 32'h1111_2222, 0));
        repeat (2) tab.push_back(idl(0, 0, 0, 0));
        repeat (2) tab.push_back(rdq(BA + 12, 1, 0, 0, 0));
        tab.push_back(rdq(BA + 12, 0, 0, 0, 0));
        tab.push_back(idl(0, 1, 32'hC0C0_C0C0, 0));
        do_reset();
        run_table("w2", 1'b0);

        // WAIT_CYCLES=0 responder
        tab.delete();
        tab.push_back(idl(0, 0, 0, 0));
        tab.push_back(wrq(BA, 32'h0A0A_0A0A, 0, 0, 0, 0));
        tab.push_back(wrq(BA + 60, 32'h3C3C_3C3C, 0, 0, 0, 0));
        tab.push_back(rdq(BA, 0, 0, 0, 0));
        tab.push_back(rdq(BA + 60, 0, 1, 32'h0A0A_0A0A, 0));
        tab.push_back(idl(0, 1, 32'h3C3C_3C3C, 0));
        tab.push_back(idl(0, 0, 32'h3C3C_3C3C, 0));
        tab.push_back(v(0, 1, BA + 4, 1, 1, BA + 4, 32'h77,
                        1, 0, 32'h3C3C_3C3C, 0));
        tab.push_back(v(0, 1, BA + 4, 1, 1, BA + 4, 32'h77,
                        0, 0, 32'h3C3C_3C3C, 0));
        tab.push_back(idl(0, 1, 32'h77, 0));
        tab.push_back(rdq(MISS, 0, 0, 32'h77, 0));
        tab.push_back(idl(0, 1, 0, 1));
        do_reset();
        run_table("w0", 1'b1);

        // read latency on the wait-state responder, bounded wait
        repeat (8) begin
            @(posedge clk);
            #1;
            rd_req = 1'b0;
            wr_req = 1'b0;
        end
        @(posedge clk);
        #1;
        rd_req = 1'b1;
        rd_addr = BA + 8;
        lat = 0;
        got = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) rd_req = 1'b0;
            if (rd_valid_a) begin
                lat = c;
                got = rd_data_a;
                break;
            end
        end
        chk("lat_latency", 32'(lat), 32'd3);
        chk("lat_data", got, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        chk("lat_single_pulse", 32'(rd_valid_a), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
